dmem_ctrl: RTL
==============

# dmem_ctrl

Parametrised byte-addressed data memory for the single-cycle RV32 core, sitting between the execute stage's address/store-data outputs and the write-back mux. It supports all RV32I load/store widths (byte, halfword, word), sign and zero extension, and per-lane byte writes. It flags misaligned and out-of-range accesses. Reads are synchronous with a one-cycle latency and a valid strobe; stores commit on the clock edge.

## Interface
Parameters:
- DEPTH, 32: memory depth in 32-bit words; power of two, at least 4.
- ADDR_W, 32: width of the byte address input.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- addr  input  ADDR_W  byte address of the access.
- wdata  input  32  store data, right-aligned (the byte or halfword is in the low bits).
- load  input  1  load request, sampled at the rising edge.
- store  input  1  store request, sampled at the rising edge.
- funct3  input  3  RV32 width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- rdata  output  32  extended load result.
- rvalid  output  1  one-cycle pulse; rdata is updated this cycle.
- misaligned  output  1  one-cycle pulse; the previous request was misaligned.
- out_of_range  output  1  one-cycle pulse; the previous request was at or beyond DEPTH*4.
- bad_req  output  1  one-cycle pulse; the previous request was illegal (load and store together, or bad funct3).

## Operation
- Word index is addr[clog2(DEPTH)+1:2]; byte offset is addr[1:0].
- Alignment:
  - Halfword needs addr[0]=0.
  - Word needs addr[1:0]=00.
  - Byte is always aligned.
- Store:
  - Byte-enable is derived from funct3 and offset: SB gives 0001 shifted by the offset; SH gives 0011 shifted by the offset; SW gives 1111.
  - wdata is replicated into the enabled lanes; non-enabled lanes keep their old contents.
- Load:
  - The addressed word is read and shifted right by offset*8.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- Suppressed requests: any misaligned, out-of-range or illegal request performs no write and no rdata update. rvalid stays 0 and the matching error pulse is raised.
  - A store with funct3 of 100 or 101 is illegal.
  - A funct3 of 011, 110 or 111 is illegal.
- Idle: rdata holds its last value between loads.
- Memory contents are not reset; simulation initial contents are zero.
- Error pulses: more than one may assert in the same cycle (for example, misaligned and out-of-range together).

## Timing
- Reset: rdata=0, rvalid=0, misaligned=0, out_of_range=0, bad_req=0, effective immediately on rst assertion and held while rst=1. Requests are ignored while rst=1.
- Load latency: a request sampled at edge N gives rdata/rvalid valid after edge N, and rvalid drops after N+1 unless another load is sampled at N+1.
- Store: the write commits at the sampling edge. A load to the same word sampled at the next edge returns the new data (no forwarding is needed, because read and write occur at separate edges).
- Back-to-back loads: one per cycle, full throughput.
- Reset mid-operation: a load in flight is discarded (rvalid=0). A store already committed at an earlier edge is retained.
- Error flags: registered, one cycle after the offending request, and aligned with where rvalid would have been.

## Structure
- Package dmem_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Function be_gen(funct3, offset) returning a 4-bit byte-enable.
  - Function load_ext(word, funct3, offset) returning a 32-bit result.
- Sub-module dmem_bank: a DEPTH x 32 array with a 4-bit byte-enable write and a registered read. It is inferable as block RAM.
- dmem_ctrl contains the decode, the alignment/range checks, the output registers and the error-pulse registers.

## Test plan
- Reset during load: load sampled, then rst asserted before the next edge -> rdata=0, rvalid=0 immediately; after release, the address still holds its stored value.
- Word round trip: SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata=0xDEADBEEF, rvalid=1 for exactly one cycle.
- Byte lanes and extension: SW 0x00000000 @0x20; SB 0x80 @0x23; SH 0x1234 @0x20:
  - LW @0x20 -> 0x80001234.
  - LB @0x23 -> 0xFFFFFF80.
  - LBU @0x23 -> 0x00000080.
  - LH @0x20 -> 0x00001234.
- Misaligned and range:
  - LW @0x22 -> misaligned=1, rvalid=0, rdata unchanged.
  - SH @0x21 -> misaligned=1, memory unchanged.
  - LW @DEPTH*4 -> out_of_range=1.
- Illegal requests: load=store=1 @0x10 -> bad_req=1, no write. funct3=011 -> bad_req=1.
- Throughput: a stream of 8 consecutive LW @0x00..0x1C -> 8 consecutive rvalid cycles, with rdata in address order.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory: RV32 width codes, request decode
// record and the lane/extension helpers used by the controller.
package dmem_pkg;

   // RV32 load/store width codes carried on funct3.
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Outcome of decoding one request in the cycle it is presented.
   typedef struct packed {
      logic illegal;
      logic misaligned;
      logic out_of_range;
      logic rd_en;
      logic wr_en;
   } req_dec_t;

   // Width codes a load may carry.
   function automatic logic load_f3_ok(input logic [2:0] funct3);
      return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
   endfunction

   // Width codes a store may carry; the unsigned forms have no store meaning.
   function automatic logic store_f3_ok(input logic [2:0] funct3);
      return funct3 inside {F3_B, F3_H, F3_W};
   endfunction

   // Halfwords need an even address, words a 4-byte aligned one.
   function automatic logic misaligned_chk(input logic [2:0] funct3,
                                           input logic [1:0] offset);
      logic bad;
      bad = 1'b0;
      case (funct3)
         F3_H, F3_HU: bad = offset[0];
         F3_W:        bad = |offset;
         default:     bad = 1'b0;
      endcase
      return bad;
   endfunction

   // Byte-lane enable for a store of the given width at the given offset.
   function automatic logic [3:0] be_gen(input logic [2:0] funct3,
                                         input logic [1:0] offset);
      logic [3:0] be;
      be = 4'b0000;
      case (funct3)
         F3_B:    be = 4'b0001 << offset;
         F3_H:    be = 4'b0011 << offset;
         F3_W:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Copy the right-aligned store data into every lane it could land in,
   // so the byte enable alone selects the destination.
   function automatic logic [31:0] wdata_rep(input logic [2:0]  funct3,
                                             input logic [31:0] wdata);
      logic [31:0] rep;
      rep = wdata;
      case (funct3)
         F3_B:    rep = {4{wdata[7:0]}};
         F3_H:    rep = {2{wdata[15:0]}};
         default: rep = wdata;
      endcase
      return rep;
   endfunction

   // Shift the addressed lanes down and sign/zero extend to 32 bits.
   function automatic logic [31:0] load_ext(input logic [31:0] word,
                                            input logic [2:0]  funct3,
                                            input logic [1:0]  offset);
      logic [31:0] sh;
      logic [31:0] res;
      sh  = word >> {offset, 3'b000};
      res = sh;
      case (funct3)
         F3_B:    res = {{24{sh[7]}}, sh[7:0]};
         F3_H:    res = {{16{sh[15]}}, sh[15:0]};
         F3_BU:   res = {24'h0, sh[7:0]};
         F3_HU:   res = {16'h0, sh[15:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the execute stage and the data memory.
interface dmem_ctrl_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic              load;
   logic              store;
   logic [2:0]        funct3;
   logic [31:0]       rdata;
   logic              rvalid;
   logic              misaligned;
   logic              out_of_range;
   logic              bad_req;

   // Core side: issues requests, consumes results and error pulses.
   modport master (
      output addr, wdata, load, store, funct3,
      input  rdata, rvalid, misaligned, out_of_range, bad_req
   );

   // Memory side.
   modport slave (
      input  addr, wdata, load, store, funct3,
      output rdata, rvalid, misaligned, out_of_range, bad_req
   );
endinterface

// File: rtl/dmem_bank.sv
// DEPTH x 32 storage with per-byte write enables and a registered read port,
// written in the shape block-RAM inference expects.
module dmem_bank #(
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic [$clog2(DEPTH)-1:0] idx,
   input  logic                     wr_en,
   input  logic [3:0]               be,
   input  logic [31:0]              wdata,
   input  logic                     rd_en,
   output logic [31:0]              q
);

   logic [31:0] mem [DEPTH];

   // Byte-lane writes and registered read; the read register holds between reads.
   // NOTE: no reset on the array or its read register -- a reset would stop
   // the tools from mapping them onto a RAM macro.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en && be[i]) begin
            mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
      if (rd_en) begin
         q <= mem[idx];
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: decodes width/alignment/range/legality of each
// request, drives the bank, and registers the load result and error pulses.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 32
) (
   input  logic         clk,
   input  logic         rst,
   dmem_ctrl_if.slave   bus
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [1:0]       offset;
   logic [IDX_W-1:0] idx;
   logic             addr_high;
   req_dec_t         dec;

   logic [31:0]      bank_q;
   logic             loaded_q;
   logic [2:0]       f3_q;
   logic [1:0]       off_q;
   logic             rvalid_q;
   logic             mis_q;
   logic             oor_q;
   logic             bad_q;

   assign offset = bus.addr[1:0];
   assign idx    = bus.addr[IDX_W+1:2];

   // Any address bit above the word index means the access is beyond DEPTH*4.
   if (ADDR_W > IDX_W + 2) begin : g_range
      assign addr_high = |bus.addr[ADDR_W-1:IDX_W+2];
   end else begin : g_no_range
      assign addr_high = 1'b0;
   end

   // Classify the request presented this cycle and decide whether it may proceed.
   always_comb begin
      logic any_req;
      logic ok;
      // NOTE: every field gets a value before any condition so no latch is inferred.
      dec     = '0;
      any_req = bus.load | bus.store;

      dec.illegal      = (bus.load & bus.store)
                       | (bus.load  & ~load_f3_ok(bus.funct3))
                       | (bus.store & ~store_f3_ok(bus.funct3));
      dec.misaligned   = any_req & misaligned_chk(bus.funct3, offset);
      dec.out_of_range = any_req & addr_high;

      ok         = ~(dec.illegal | dec.misaligned | dec.out_of_range) & ~rst;
      dec.rd_en  = bus.load  & ok;
      dec.wr_en  = bus.store & ok;
   end

   dmem_bank #(
      .DEPTH (DEPTH)
   ) u_bank (
      .clk   (clk),
      .idx   (idx),
      .wr_en (dec.wr_en),
      .be    (be_gen(bus.funct3, offset)),
      .wdata (wdata_rep(bus.funct3, bus.wdata)),
      .rd_en (dec.rd_en),
      .q     (bank_q)
   );

   // Status pulses and the width/offset of the last accepted load.
   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         mis_q    <= 1'b0;
         oor_q    <= 1'b0;
         bad_q    <= 1'b0;
         loaded_q <= 1'b0;
         f3_q     <= F3_W;
         off_q    <= 2'b00;
      end else begin
         rvalid_q <= dec.rd_en;
         mis_q    <= dec.misaligned;
         oor_q    <= dec.out_of_range;
         bad_q    <= dec.illegal;
         if (dec.rd_en) begin
            loaded_q <= 1'b1;
            f3_q     <= bus.funct3;
            off_q    <= offset;
         end
      end
   end

   // The bank read register is not reset, so rdata is forced to zero until
   // a load has landed since the last reset; after that it holds between loads.
   assign bus.rdata        = loaded_q ? load_ext(bank_q, f3_q, off_q) : 32'h0;
   assign bus.rvalid       = rvalid_q;
   assign bus.misaligned   = mis_q;
   assign bus.out_of_range = oor_q;
   assign bus.bad_req      = bad_q;

endmodule
